reg_bus_master: RTL and testbench

Initiator for the GPIO register-file bus: accepts single read/write commands on a valid/ready command port and drives the register block's `addr`/`wben`/`r_wn`/`wdata` pins, capturing `rdata` for reads. It sits between the system-side control logic and the register block and is the only driver of that bus. It produces exactly one response per accepted command.

---
 rtl/reg_bus_master.sv | 193 +++++++++++++++++++
 tb/tb_reg_bus_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_master.sv
// rtl/reg_bus_master.sv - single-command initiator for the GPIO register-file bus
//
// Accepts one read or write command at a time on a valid/ready port, runs the
// corresponding cycle on the register-block bus, and returns exactly one
// response per accepted command.
//
// Optional feature: define REG_MASTER_READBACK_EN to follow every write with a
// read-back of the same address; the response then carries the read-back data
// and rsp_err flags any enabled byte lane that did not take the written value.
// Without the macro rsp_err is tied low and writes respond with rsp_rdata = 0.
//
// Parameters:
//   READ_LAT   cycles from read address presented to rdata sampled (1..3)
//
// Ports:
//   clk, reset                       clock; asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write, cmd_addr, cmd_wben,
//   cmd_wdata                        command fields (held by source until accept)
//   rsp_valid/rsp_ready              response handshake
//   rsp_rdata, rsp_err               read data / read-back data, read-back mismatch
//   addr, wben, r_wn, wdata          register bus outputs (r_wn: 1 = read)
//   rdata                            register bus read data
//   busy                             high whenever the FSM is not idle

module reg_bus_master #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [2:0]  cmd_addr,
  input  logic [3:0]  cmd_wben,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [2:0]  addr,
  output logic [3:0]  wben,
  output logic        r_wn,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
`ifdef REG_MASTER_READBACK_EN
    S_RB,
`endif
    S_RESP
  } state_t;

  // Read wait counts down from READ_LAT-1; the cycle that sees zero is the
  // last one, and rdata is captured on the edge that ends it.
  localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);

  state_t     state;
  logic [1:0] lat_cnt;

`ifdef REG_MASTER_READBACK_EN
  // The bus wben drops to zero during read-back, so the lanes that were
  // written are kept separately for the comparison.
  logic [3:0] rb_wben;
  logic       rb_mismatch;

  always_comb begin
    rb_mismatch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rb_wben[i] && (rdata[8*i +: 8] != wdata[8*i +: 8])) begin
        rb_mismatch = 1'b1;
      end
    end
  end
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      lat_cnt   <= 2'd0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      addr      <= 3'd0;
      wben      <= 4'd0;
      r_wn      <= 1'b1;
      wdata     <= 32'd0;
      busy      <= 1'b0;
`ifdef REG_MASTER_READBACK_EN
      rsp_err   <= 1'b0;
      rb_wben   <= 4'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            addr      <= cmd_addr;
            wdata     <= cmd_wdata;
            lat_cnt   <= LAT_LAST;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef REG_MASTER_READBACK_EN
            rb_wben   <= cmd_wbit_mask(cmd_write, cmd_wben);
`endif
            if (cmd_write) begin
              state <= S_WR;
              r_wn  <= 1'b0;
              wben  <= cmd_wben;
            end else begin
              state <= S_RD;
            end
          end
        end

        // One-cycle write strobe; the register block captures on the edge
        // ending this cycle. wben = 0 still runs the cycle and completes.
        S_WR: begin
          r_wn <= 1'b1;
          wben <= 4'd0;
`ifdef REG_MASTER_READBACK_EN
          state   <= S_RB;
          lat_cnt <= LAT_LAST;
`else
          state     <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= 32'd0;
`endif
        end

        S_RD: begin
          if (lat_cnt == 2'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata;
`ifdef REG_MASTER_READBACK_EN
            rsp_err   <= 1'b0;
`endif
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end

`ifdef REG_MASTER_READBACK_EN
        // Read-only registers (pin state) will legitimately mismatch here;
        // the flag is reported and interpretation is left to software.
        S_RB: begin
          if (lat_cnt == 2'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdata;
            rsp_err   <= rb_mismatch;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
`endif

        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          r_wn      <= 1'b1;
          wben      <= 4'd0;
        end
      endcase
    end
  end

`ifdef REG_MASTER_READBACK_EN
  // Reads never compare lanes, so only a write keeps its byte enables.
  function automatic logic [3:0] cmd_wbit_mask(input logic is_write, input logic [3:0] be);
    return is_write ? be : 4'd0;
  endfunction
`endif

endmodule

// File: tb/tb_reg_bus_master.sv
// tb/tb_reg_bus_master.sv - directed self-checking bench for reg_bus_master
module tb_reg_bus_master;

`ifdef REG_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT a: READ_LAT = 1, owns the write path into the register model
  logic        a_cmd_valid = 0, a_cmd_ready, a_cmd_write = 0;
  logic [2:0]  a_cmd_addr = 0;
  logic [3:0]  a_cmd_wben = 0;
  logic [31:0] a_cmd_wdata = 0;
  logic        a_rsp_valid, a_rsp_ready = 1, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic [2:0]  a_addr;
  logic [3:0]  a_wben;
  logic        a_r_wn, a_busy;
  logic [31:0] a_wdata, a_rdata;

  // DUT b: READ_LAT = 3, read-only user of the same register model
  logic        b_cmd_valid = 0, b_cmd_ready, b_cmd_write = 0;
  logic [2:0]  b_cmd_addr = 0;
  logic [3:0]  b_cmd_wben = 0;
  logic [31:0] b_cmd_wdata = 0;
  logic        b_rsp_valid, b_rsp_ready = 1, b_rsp_err;
  logic [31:0] b_rsp_rdata;
  logic [2:0]  b_addr;
  logic [3:0]  b_wben;
  logic        b_r_wn, b_busy;
  logic [31:0] b_wdata, b_rdata;

  reg_bus_master #(.READ_LAT(1)) u_dut_a (
    .clk(clk), .reset(rst_n),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(a_cmd_write),
    .cmd_addr(a_cmd_addr), .cmd_wben(a_cmd_wben), .cmd_wdata(a_cmd_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .addr(a_addr), .wben(a_wben), .r_wn(a_r_wn), .wdata(a_wdata), .rdata(a_rdata), .busy(a_busy)
  );

  reg_bus_master #(.READ_LAT(3)) u_dut_b (
    .clk(clk), .reset(rst_n),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(b_cmd_write),
    .cmd_addr(b_cmd_addr), .cmd_wben(b_cmd_wben), .cmd_wdata(b_cmd_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .addr(b_addr), .wben(b_wben), .r_wn(b_r_wn), .wdata(b_wdata), .rdata(b_rdata), .busy(b_busy)
  );

  // Register block model: word 7 is read-only pin state (pins = 0).
  logic [31:0] mem [8];
  logic        mem_load = 1'b1;
  logic [31:0] b_d1, b_d2;

  always @(posedge clk) begin
    if (mem_load) begin
      mem[0] <= 32'h0BAD_0000; mem[1] <= 32'h0000_0000;
      mem[2] <= 32'hDEAD_BEEF; mem[3] <= 32'h3333_3333;
      mem[4] <= 32'h0000_0000; mem[5] <= 32'h5555_5555;
      mem[6] <= 32'h1234_5678; mem[7] <= 32'h0000_0000;
    end else if (!a_r_wn && a_addr != 3'd7) begin
      for (int i = 0; i < 4; i++)
        if (a_wben[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  assign a_rdata = (a_addr == 3'd7) ? 32'd0 : mem[a_addr];

  // Three-cycle read path: data for an address is valid only after two flops.
  always @(posedge clk) begin
    b_d1 <= (b_addr == 3'd7) ? 32'd0 : mem[b_addr];
    b_d2 <= b_d1;
  end
  assign b_rdata = b_d2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Runs one command on DUT a with rsp_ready high. Returns at the first
  // sample (1 time unit after an edge) where rsp_valid is high; lat counts
  // edges after the accept edge. Bus cycles are audited along the way.
  task automatic run_a(input logic wr, input logic [2:0] ad, input logic [3:0] be,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output int wrc, output int bad);
    @(posedge clk); #1;
    check("accept_ready", 32'(a_cmd_ready), 1);
    a_cmd_valid = 1'b1; a_cmd_write = wr; a_cmd_addr = ad;
    a_cmd_wben = be; a_cmd_wdata = wd; a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    lat = 0; wrc = 0; bad = 0;
    while (!a_rsp_valid && lat < 40) begin
      if (a_addr !== ad) bad++;
      if (!a_r_wn) begin
        wrc++;
        if (a_wben !== be || a_wdata !== wd) bad++;
      end else if (a_wben !== 4'd0) begin
        bad++;
      end
      @(posedge clk); #1;
      lat++;
    end
    rd = a_rsp_rdata;
    er = a_rsp_err;
  endtask

  localparam int WR_LAT_A = RB ? 2 : 1;

  logic [31:0] rd;
  logic        er;
  int          lat, wrc, bad, n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(a_cmd_ready), 1);
    check("rst_rsp_valid", 32'(a_rsp_valid), 0);
    check("rst_rsp_rdata", a_rsp_rdata, 0);
    check("rst_rsp_err",   32'(a_rsp_err), 0);
    check("rst_addr",      32'(a_addr), 0);
    check("rst_wben",      32'(a_wben), 0);
    check("rst_r_wn",      32'(a_r_wn), 1);
    check("rst_wdata",     a_wdata, 0);
    check("rst_busy",      32'(a_busy), 0);
    check("rst_b_busy",    32'(b_busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_load = 1'b0;

    // write 6 / 0011 / FFFF_9249: low half becomes 9249
    run_a(1'b1, 3'd6, 4'b0011, 32'hFFFF_9249, rd, er, lat, wrc, bad);
    check("wr1_lat", 32'(lat), 32'(WR_LAT_A));
    check("wr1_wr_cycles", 32'(wrc), 1);
    check("wr1_bus", 32'(bad), 0);
    check("wr1_rdata", rd, RB ? 32'h1234_9249 : 32'h0);
    check("wr1_err", 32'(er), 0);
    check("wr1_reg", mem[6], 32'h1234_9249);

    // read it back
    run_a(1'b0, 3'd6, 4'b0000, 32'h0, rd, er, lat, wrc, bad);
    check("rd6_lat", 32'(lat), 1);
    check("rd6_wr_cycles", 32'(wrc), 0);
    check("rd6_bus", 32'(bad), 0);
    check("rd6_rdata", rd, 32'h1234_9249);
    check("rd6_err", 32'(er), 0);

    // wben = 0 write still runs, changes nothing
    run_a(1'b1, 3'd6, 4'b0000, 32'h0000_8001, rd, er, lat, wrc, bad);
    check("wb0_lat", 32'(lat), 32'(WR_LAT_A));
    check("wb0_wr_cycles", 32'(wrc), 1);
    check("wb0_bus", 32'(bad), 0);
    check("wb0_rdata", rd, RB ? 32'h1234_9249 : 32'h0);
    check("wb0_err", 32'(er), 0);
    check("wb0_reg", mem[6], 32'h1234_9249);

    // full-word write and read of another register
    run_a(1'b1, 3'd1, 4'b1111, 32'hA5A5_5A5A, rd, er, lat, wrc, bad);
    check("wr1f_rdata", rd, RB ? 32'hA5A5_5A5A : 32'h0);
    check("wr1f_reg", mem[1], 32'hA5A5_5A5A);
    run_a(1'b0, 3'd2, 4'b0000, 32'h0, rd, er, lat, wrc, bad);
    check("rd2_rdata", rd, 32'hDEAD_BEEF);

    // response stall: rsp_ready low for 5 cycles with a second command waiting
    @(posedge clk); #1;
    a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = 3'd2; a_rsp_ready = 1'b0;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("stall_rsp_valid", 32'(a_rsp_valid), 1);
    a_cmd_valid = 1'b1; a_cmd_write = 1'b0; a_cmd_addr = 3'd1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_hold_valid", 32'(a_rsp_valid), 1);
      check("stall_hold_rdata", a_rsp_rdata, 32'hDEAD_BEEF);
      check("stall_cmd_ready", 32'(a_cmd_ready), 0);
      @(posedge clk);
    end
    #1 a_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_cmd_ready", 32'(a_cmd_ready), 1);
    check("post_hs_rsp_valid", 32'(a_rsp_valid), 0);
    check("post_hs_busy", 32'(a_busy), 0);
    @(posedge clk); #1;
    check("second_accept_busy", 32'(a_busy), 1);
    check("second_accept_ready", 32'(a_cmd_ready), 0);
    a_cmd_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("second_rdata", a_rsp_rdata, 32'hA5A5_5A5A);

    // read-back: pin-state register mismatches, RW register matches
    run_a(1'b1, 3'd7, 4'b0001, 32'h0000_00A5, rd, er, lat, wrc, bad);
    check("pin_err", 32'(er), RB ? 1 : 0);
    check("pin_rdata", rd, 32'h0);
    run_a(1'b1, 3'd3, 4'b0001, 32'h0000_00A5, rd, er, lat, wrc, bad);
    check("rw_err", 32'(er), 0);
    check("rw_rdata", rd, RB ? 32'h3333_33A5 : 32'h0);
    check("rw_reg", mem[3], 32'h3333_33A5);

    // reset in the middle of a write cycle abandons it
    @(posedge clk); #1;
    a_cmd_valid = 1'b1; a_cmd_write = 1'b1; a_cmd_addr = 3'd5;
    a_cmd_wben = 4'b1111; a_cmd_wdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    a_cmd_valid = 1'b0;
    check("wr_cycle_r_wn", 32'(a_r_wn), 0);
    #2 rst_n = 1'b0;
    #1;
    check("wr_rst_r_wn", 32'(a_r_wn), 1);
    check("wr_rst_wben", 32'(a_wben), 0);
    check("wr_rst_busy", 32'(a_busy), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("wr_rst_reg", mem[5], 32'h5555_5555);
    check("wr_rst_no_rsp", 32'(a_rsp_valid), 0);

    // reset during the READ_LAT = 3 wait
    @(posedge clk); #1;
    b_cmd_valid = 1'b1; b_cmd_write = 1'b0; b_cmd_addr = 3'd6; b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rdw_busy", 32'(b_busy), 1);
    check("rdw_rsp_valid", 32'(b_rsp_valid), 0);
    #2 rst_n = 1'b0;
    #1;
    check("rdw_rst_r_wn", 32'(b_r_wn), 1);
    check("rdw_rst_busy", 32'(b_busy), 0);
    check("rdw_rst_rsp_valid", 32'(b_rsp_valid), 0);
    check("rdw_rst_cmd_ready", 32'(b_cmd_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin @(negedge clk); if (b_rsp_valid) n++; end
    check("rdw_no_rsp", 32'(n), 0);
    check("rdw_cmd_ready", 32'(b_cmd_ready), 1);

    // normal READ_LAT = 3 read after recovery
    @(posedge clk); #1;
    b_cmd_valid = 1'b1; b_cmd_addr = 3'd6;
    @(posedge clk); #1;
    b_cmd_valid = 1'b0;
    n = 0;
    while (!b_rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("rd3_lat", 32'(n), 3);
    check("rd3_rdata", b_rsp_rdata, 32'h1234_9249);
    check("rd3_r_wn", 32'(b_r_wn), 1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
